// File: rtl/instr_register_mc.sv
// Multi-cycle instruction register: single-cycle ALU ops, iterative DIV/MOD, DEPTH-entry file.
// Optional per-entry error flag and rd_err port enabled by defining INSTR_REG_ERR_EN.
package instr_register_pkg;
    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;
endpackage

module instr_register_mc
    import instr_register_pkg::*;
#(
    parameter int OP_WIDTH = 32,
    parameter int DEPTH    = 32
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          load_en,
    output logic                          load_rdy,
    input  opcode_t                       opcode,
    input  logic signed [OP_WIDTH-1:0]    operand_a,
    input  logic signed [OP_WIDTH-1:0]    operand_b,
    input  logic [$clog2(DEPTH)-1:0]      write_pointer,
    input  logic                          read_en,
    input  logic [$clog2(DEPTH)-1:0]      read_pointer,
    output logic                          rd_valid,
    output logic                          rd_entry_valid,
    output opcode_t                       rd_opcode,
    output logic [OP_WIDTH-1:0]           rd_op_a,
    output logic [OP_WIDTH-1:0]           rd_op_b,
    output logic [2*OP_WIDTH-1:0]         rd_result,
    output logic                          busy
`ifdef INSTR_REG_ERR_EN
    ,
    output logic                          rd_err
`endif
);
    localparam int ADDR_W    = $clog2(DEPTH);
    localparam int RES_WIDTH = 2 * OP_WIDTH;
    localparam int CNT_W     = $clog2(OP_WIDTH);

    typedef struct packed {
        logic                 valid;
`ifdef INSTR_REG_ERR_EN
        logic                 err;
`endif
        opcode_t              opcode;
        logic [OP_WIDTH-1:0]  op_a;
        logic [OP_WIDTH-1:0]  op_b;
        logic [RES_WIDTH-1:0] result;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_DIV_RUN, S_DIV_DONE} state_t;

    state_t               r_state;
    logic                 r_load_rdy;
    logic                 r_busy;
    opcode_t              r_div_op;
    logic [ADDR_W-1:0]    r_wptr;
    logic [OP_WIDTH-1:0]  r_a;
    logic [OP_WIDTH-1:0]  r_b;
    logic [OP_WIDTH-1:0]  r_quo;
    logic [OP_WIDTH-1:0]  r_rem;
    logic [OP_WIDTH-1:0]  r_dvsr;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_div0;
    entry_t               r_mem [DEPTH];
    entry_t               r_rd_entry;
    logic                 r_rd_valid;

    logic                 w_accept;
    logic                 w_is_div;
    logic [RES_WIDTH-1:0] w_a_ext;
    logic [RES_WIDTH-1:0] w_b_ext;
    logic [RES_WIDTH-1:0] w_alu_res;
    logic [OP_WIDTH-1:0]  w_mag_a;
    logic [OP_WIDTH-1:0]  w_mag_b;
    logic [OP_WIDTH:0]    w_rem_sh;
    logic [OP_WIDTH:0]    w_diff;
    logic [RES_WIDTH-1:0] w_quo_ext;
    logic [RES_WIDTH-1:0] w_rem_ext;
    logic [RES_WIDTH-1:0] w_div_res;
    logic                 w_wr_en;
    logic [ADDR_W-1:0]    w_wr_idx;
    entry_t               w_wr_entry;

    assign w_accept = load_en && r_load_rdy && (r_state == S_IDLE);
    assign w_is_div = (opcode == DIV) || (opcode == MOD);

    assign w_a_ext = {{OP_WIDTH{operand_a[OP_WIDTH-1]}}, operand_a};
    assign w_b_ext = {{OP_WIDTH{operand_b[OP_WIDTH-1]}}, operand_b};

    // Operands are widened first, so ADD/SUB cannot overflow and MULT keeps the full product.
    always_comb begin
        // NOTE: default first so every path assigns w_alu_res and no latch is inferred.
        w_alu_res = '0;
        case (opcode)
            PASSA:   w_alu_res = w_a_ext;
            PASSB:   w_alu_res = w_b_ext;
            ADD:     w_alu_res = w_a_ext + w_b_ext;
            SUB:     w_alu_res = w_a_ext - w_b_ext;
            MULT:    w_alu_res = w_a_ext * w_b_ext;
            default: w_alu_res = '0;
        endcase
    end

    assign w_mag_a = operand_a[OP_WIDTH-1] ? OP_WIDTH'(-operand_a) : operand_a;
    assign w_mag_b = operand_b[OP_WIDTH-1] ? OP_WIDTH'(-operand_b) : operand_b;

    // One restoring step: shift the next dividend bit in and subtract if it fits.
    assign w_rem_sh = {r_rem, r_quo[OP_WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_dvsr};

    assign w_quo_ext = {{OP_WIDTH{1'b0}}, r_quo};
    assign w_rem_ext = {{OP_WIDTH{1'b0}}, r_rem};

    always_comb begin
        w_div_res = '0;
        if (r_div0) begin
            w_div_res = (r_div_op == DIV) ? '1 : {{OP_WIDTH{r_a[OP_WIDTH-1]}}, r_a};
        end else if (r_div_op == DIV) begin
            w_div_res = (r_a[OP_WIDTH-1] ^ r_b[OP_WIDTH-1]) ? -w_quo_ext : w_quo_ext;
        end else begin
            w_div_res = r_a[OP_WIDTH-1] ? -w_rem_ext : w_rem_ext;
        end
    end

    always_comb begin
        w_wr_en    = 1'b0;
        w_wr_idx   = write_pointer;
        w_wr_entry = '0;
        if (w_accept && !w_is_div) begin
            w_wr_en           = 1'b1;
            w_wr_entry.valid  = 1'b1;
            w_wr_entry.opcode = opcode;
            w_wr_entry.op_a   = operand_a;
            w_wr_entry.op_b   = operand_b;
            w_wr_entry.result = w_alu_res;
        end else if (r_state == S_DIV_DONE) begin
            w_wr_en           = 1'b1;
            w_wr_idx          = r_wptr;
            w_wr_entry.valid  = 1'b1;
`ifdef INSTR_REG_ERR_EN
            w_wr_entry.err    = r_div0;
`endif
            w_wr_entry.opcode = r_div_op;
            w_wr_entry.op_a   = r_a;
            w_wr_entry.op_b   = r_b;
            w_wr_entry.result = w_div_res;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_load_rdy <= 1'b1;
            r_busy     <= 1'b0;
            r_div_op   <= ZERO;
            r_wptr     <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_dvsr     <= '0;
            r_cnt      <= '0;
            r_div0     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_is_div) begin
                        r_div_op   <= opcode;
                        r_wptr     <= write_pointer;
                        r_a        <= operand_a;
                        r_b        <= operand_b;
                        r_quo      <= w_mag_a;
                        r_rem      <= '0;
                        r_dvsr     <= w_mag_b;
                        r_cnt      <= '0;
                        r_div0     <= (operand_b == '0);
                        r_load_rdy <= 1'b0;
                        r_busy     <= (operand_b != '0);
                        r_state    <= (operand_b == '0) ? S_DIV_DONE : S_DIV_RUN;
                    end else begin
                        r_load_rdy <= 1'b1;
                    end
                end
                S_DIV_RUN: begin
                    if (!w_diff[OP_WIDTH]) begin
                        r_rem <= w_diff[OP_WIDTH-1:0];
                        r_quo <= {r_quo[OP_WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_rem_sh[OP_WIDTH-1:0];
                        r_quo <= {r_quo[OP_WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(OP_WIDTH - 1)) begin
                        r_busy  <= 1'b0;
                        r_state <= S_DIV_DONE;
                    end
                end
                S_DIV_DONE: r_state <= S_IDLE;
                default:    r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the file is reset explicitly because entry valid bits and contents must read as zero.
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_wr_en) begin
            r_mem[w_wr_idx] <= w_wr_entry;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_valid <= 1'b0;
            r_rd_entry <= '0;
        end else begin
            r_rd_valid <= read_en;
            if (read_en) r_rd_entry <= r_mem[read_pointer];
        end
    end

    assign load_rdy       = r_load_rdy;
    assign busy           = r_busy;
    assign rd_valid       = r_rd_valid;
    assign rd_entry_valid = r_rd_entry.valid;
    assign rd_opcode      = r_rd_entry.opcode;
    assign rd_op_a        = r_rd_entry.op_a;
    assign rd_op_b        = r_rd_entry.op_b;
    assign rd_result      = r_rd_entry.result;
`ifdef INSTR_REG_ERR_EN
    assign rd_err         = r_rd_entry.err;
`endif

endmodule

// File: doc/instr_register_mc.md
Name: instr_register_mc

Overview:
Parametrised, multi-cycle successor to the single-cycle instruction register. Accepts instructions (opcode plus two signed operands) through a valid/ready write port. Computes the result, using a single-cycle ALU for most ops and an iterative divider for DIV/MOD. Stores opcode, operands and result in a DEPTH-entry register file, read through a registered read port with per-entry valid flags; sits between the stimulus/issue logic and the result checker.

Parameters:
OP_WIDTH, 32, operand width in bits; signed two's complement; range 4..64.
DEPTH, 32, number of entries; power of two, >= 2.
ADDR_W, $clog2(DEPTH), localparam, not overridable.
RES_WIDTH, 2*OP_WIDTH, localparam, result width.

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
load_en  in  1  write request valid.
load_rdy  out  1  write request ready; transfer on load_en && load_rdy at posedge clk.
opcode  in  opcode_t  instr_register_pkg opcode (ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD).
operand_a  in  OP_WIDTH  signed operand A.
operand_b  in  OP_WIDTH  signed operand B.
write_pointer  in  ADDR_W  destination entry.
read_en  in  1  read request.
read_pointer  in  ADDR_W  entry to read.
rd_valid  out  1  read data valid, one cycle after read_en.
rd_entry_valid  out  1  addressed entry has been written since reset.
rd_opcode  out  opcode_t  stored opcode.
rd_op_a  out  OP_WIDTH  stored operand A.
rd_op_b  out  OP_WIDTH  stored operand B.
rd_result  out  RES_WIDTH  stored result.
busy  out  1  divider in progress.

Behaviour:
- Reset (async, reset_n low): FSM to IDLE; all entries cleared to {ZERO,0,0,0}; entry valid bits cleared. Outputs: load_rdy=1, busy=0, rd_valid=0, rd_entry_valid=0, rd_* = 0.
- FSM states: IDLE, DIV_RUN, DIV_DONE.
- IDLE, load_rdy=1:
  - Accepted ZERO/PASSA/PASSB/ADD/SUB/MULT: entry[write_pointer] and its valid bit are written at the accepting edge. Back-to-back accepts every cycle are allowed.
- Accepted DIV/MOD:
  - Operands, opcode and pointer are captured; FSM goes to DIV_RUN; load_rdy=0, busy=1.
  - DIV_RUN lasts exactly OP_WIDTH cycles (restoring division on magnitudes), then DIV_DONE.
  - DIV_DONE writes the entry and returns to IDLE. The entry becomes visible OP_WIDTH+1 edges after accept.
  - load_rdy rises in the cycle after the DIV_DONE write.
- Divide by zero: DIV_RUN is skipped, IDLE -> DIV_DONE. DIV result = all ones (-1); MOD result = sign-extended operand_a.
- Arithmetic: all ops signed and sign-extended to RES_WIDTH.
  - PASSA = a; PASSB = b; ADD/SUB are computed at OP_WIDTH+1 bits with no overflow; MULT is the full 2*OP_WIDTH product.
  - DIV truncates toward zero. MOD takes the sign of the dividend, with a = q*b + r.
  - Most-negative / -1 = +2^(OP_WIDTH-1), exact in RES_WIDTH.
  - ZERO and unlisted encodings: result 0, opcode stored as given.
- load_en while load_rdy=0: ignored, not queued. Inputs need not be held while busy.
- Read port: registered, one-cycle latency. rd_* and rd_entry_valid reflect entry[read_pointer] as it was before any write on the same edge (read-before-write). rd_* hold their last value when read_en=0; rd_valid pulses for one cycle.
- Reading an entry whose DIV is still in flight returns its previous contents.
- Reset mid-division: operation aborted, nothing written, IDLE on reset release.

Optional Feature:
INSTR_REG_ERR_EN
- Defined: adds an output port rd_err (1 bit) and a per-entry error bit. The bit is set when the write was DIV/MOD by zero or an unlisted opcode, and is cleared by reset. rd_err follows the same read timing as rd_result.
- Undefined: no port, no storage; results exactly as in Behaviour.

Test Plan:
- Reset, then read_en on each of the 32 entries -> rd_valid one cycle later; rd_entry_valid=0; all rd_* = 0.
- Back-to-back ADD(7,-3)@0, SUB(-5,10)@1, MULT(-65536,65536)@2, load_en held high -> load_rdy stays 1; reads return 4, -15, -2^32 sign-extended to 64 bits.
- DIV(-7,2)@5 -> busy for 32 cycles, load_rdy low 34 cycles; entry 5 = -3. MOD(-7,2)@6 -> entry 6 = -1.
- DIV(0x80000000,-1)@9 -> result 0x0000_0000_8000_0000. DIV(9,0)@10 -> all ones after 2 edges. MOD(9,0)@11 -> 9. With INSTR_REG_ERR_EN, rd_err=1 on entries 10 and 11 only.
- Read entry 5 on the same edge as an ADD write to entry 5 -> old value returned; a read on the next cycle returns the new value.
- Assert reset_n mid-DIV to entry 3 -> entry 3 stays invalid, busy=0 and load_rdy=1 immediately; a new ADD is accepted right after release.
